// File: rtl/usb_buf_in_arbiter_if.sv
// Signal bundle between the producers/USB core (master) and the IN-buffer arbiter (slave).
interface usb_buf_in_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [8:0]         buf_in_addr;
  logic [7:0]         buf_in_data;
  logic               buf_in_wren;
  logic               buf_in_ready;
  logic               buf_in_commit;
  logic [9:0]         buf_in_commit_len;
  logic               buf_in_commit_ack;

  modport master (
    output req_valid, req_data, req_last, buf_in_ready, buf_in_commit_ack,
    input  req_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len
  );

  modport slave (
    input  req_valid, req_data, req_last, buf_in_ready, buf_in_commit_ack,
    output req_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len
  );
endinterface

// File: rtl/usb_buf_in_arbiter.sv
// Round-robin arbiter sharing the USB IN endpoint buffer between N_REQ byte-stream producers:
// writes one packet, commits it with its length and waits for the core's acknowledge.
module usb_buf_in_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned MAX_LEN     = 512,
  parameter int unsigned ACK_TIMEOUT = 4096
) (
  input  logic                ext_clk,
  input  logic                reset_n,
  usb_buf_in_arbiter_if.slave bus,
  output logic [2:0]          grant_id,
  output logic                busy,
  output logic                err_overflow,
  output logic                err_timeout
);

  localparam int unsigned   TW          = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [9:0]    MaxLen      = 10'(MAX_LEN);
  localparam logic [TW-1:0] TimeoutLast = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StCommit, StWaitAck} state_e;

  state_e        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    last_grant_q, last_grant_d;
  logic [9:0]    byte_cnt_q, byte_cnt_d;
  logic [9:0]    commit_len_q, commit_len_d;
  logic          ovf_q, ovf_d;
  logic          wren_q, wren_d;
  logic [8:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [TW-1:0] timer_q, timer_d;

  logic       g_valid, g_last;
  logic [7:0] g_data;
  logic [2:0] pick_hi, pick_lo;
  logic       found_hi, any_req;

  // Lane of the currently granted producer.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (3'(i) == grant_q) begin
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  // Lowest requester above last_grant wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (3'(i) > last_grant_q) begin
          pick_hi  = 3'(i);
          found_hi = 1'b1;
        end else begin
          pick_lo = 3'(i);
        end
      end
    end
  end

  assign any_req = |bus.req_valid;

  always_comb begin
    bus.req_ready = '0;
    if (state_q == StWrite) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        bus.req_ready[i] = (3'(i) == grant_q);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    byte_cnt_d   = byte_cnt_q;
    commit_len_d = commit_len_q;
    ovf_d        = ovf_q;
    wren_d       = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    timer_d      = timer_q;
    err_timeout  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.buf_in_ready && any_req) begin
          grant_d    = found_hi ? pick_hi : pick_lo;
          byte_cnt_d = '0;
          ovf_d      = 1'b0;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (g_valid) begin
          if (byte_cnt_q < MaxLen) begin
            wren_d     = 1'b1;
            addr_d     = byte_cnt_q[8:0];
            data_d     = g_data;
            byte_cnt_d = byte_cnt_q + 10'd1;
          end else begin
            ovf_d = 1'b1;
          end
          if (g_last) state_d = StCommit;
        end
      end
      StCommit: begin
        commit_len_d = byte_cnt_q;
        timer_d      = '0;
        state_d      = StWaitAck;
      end
      StWaitAck: begin
        timer_d = timer_q + TW'(1);
        if (bus.buf_in_commit_ack) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end else if (timer_q == TimeoutLast) begin
          err_timeout  = 1'b1;
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= 3'(N_REQ - 1);
      byte_cnt_q   <= '0;
      commit_len_q <= '0;
      ovf_q        <= 1'b0;
      wren_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
      commit_len_q <= commit_len_d;
      ovf_q        <= ovf_d;
      wren_q       <= wren_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      timer_q      <= timer_d;
    end
  end

  // The final byte's increment lands on entry to StCommit, so the live count is shown there.
  assign bus.buf_in_commit_len = (state_q == StCommit) ? byte_cnt_q : commit_len_q;
  assign bus.buf_in_commit     = (state_q == StCommit);
  assign bus.buf_in_wren       = wren_q;
  assign bus.buf_in_addr       = addr_q;
  assign bus.buf_in_data       = data_q;
  assign err_overflow          = (state_q == StCommit) && ovf_q;
  assign grant_id              = grant_q;
  assign busy                  = (state_q != StIdle);

endmodule

// File: tb/tb_usb_buf_in_arbiter.sv
// Directed table-driven bench for usb_buf_in_arbiter: each record is one packet with its
// expected grant, commit length and error pulses; reset-abort is a hand-written sequence.
module tb_usb_buf_in_arbiter;
  localparam int ACK_TIMEOUT = 4096;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] grant_id;
  logic busy, err_overflow, err_timeout;

  usb_buf_in_arbiter_if #(.N_REQ(4)) bus ();

  usb_buf_in_arbiter #(.N_REQ(4), .MAX_LEN(512), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .ext_clk     (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_overflow(err_overflow),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    int         len;
    int         ack_dly;   // -1: never acknowledge
    int         rdy_dly;   // cycles buf_in_ready is held low first
    bit         stall;     // toggle req_valid every cycle
    int         exp_grant;
    int         exp_len;
    bit         exp_ovf;
    bit         exp_to;
  } vec_t;

  vec_t       vecs [11];
  int         n_vec = 0;
  int         n_err = 0;
  int         pcnt [4];
  logic [3:0] cur_mask;
  int         cur_len;
  bit         cur_stall;
  bit         phase;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pattern(input int p, input int k);
    return 8'(32'hA1 + 32 * p + k);
  endfunction

  task automatic drive();
    logic [3:0]  dv;
    logic [3:0]  dl;
    logic [31:0] dd;
    for (int p = 0; p < 4; p++) begin
      dv[p]        = cur_mask[p] && !(cur_stall && phase);
      dd[8*p +: 8] = pattern(p, pcnt[p]);
      dl[p]        = (pcnt[p] == cur_len - 1);
    end
    bus.req_valid = dv;
    bus.req_data  = dd;
    bus.req_last  = dl;
  endtask

  task automatic run_pkt(input vec_t v);
    int         cyc = 0, writes = 0, acc = 0, commits = 0, tos = 0, to_cyc = -1, since = 0;
    int         budget;
    bit         committed = 0, last_taken = 0, done = 0;
    logic [3:0] prev_acc;
    logic [3:0] exp_rdy;
    budget    = 3 * v.len + ACK_TIMEOUT + 64;
    cur_mask  = v.mask;
    cur_len   = v.len;
    cur_stall = 0;
    phase     = 0;
    if (v.rdy_dly > 0) begin
      bus.buf_in_ready = 1'b0;
      drive();
      for (int i = 0; i < v.rdy_dly; i++) begin
        @(negedge clk);
        chk("no_grant_busy", 32'(busy), 0);
        chk("no_grant_ready", 32'(bus.req_ready), 0);
      end
    end
    bus.buf_in_ready = 1'b1;
    cur_stall = v.stall;
    drive();
    prev_acc = bus.req_valid & bus.req_ready;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (committed) since++;
      for (int p = 0; p < 4; p++) begin
        if (prev_acc[p]) begin
          acc++;
          if (pcnt[p] == cur_len - 1) begin
            pcnt[p]    = 0;
            last_taken = 1;
          end else begin
            pcnt[p]++;
          end
        end
      end
      if (cyc == 1) chk("busy_after_grant", 32'(busy), 1);
      if (bus.buf_in_wren) begin
        chk("wr_addr", 32'(bus.buf_in_addr), writes);
        chk("wr_data", 32'(bus.buf_in_data), 32'(pattern(v.exp_grant, writes)));
        writes++;
      end
      if (busy) chk("grant_id", 32'(grant_id), v.exp_grant);
      exp_rdy = (busy && !last_taken) ? (4'b0001 << v.exp_grant) : 4'b0000;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("err_overflow", 32'(err_overflow), 32'(bus.buf_in_commit & v.exp_ovf));
      if (bus.buf_in_commit) begin
        commits++;
        chk("commit_len", 32'(bus.buf_in_commit_len), v.exp_len);
        committed = 1;
        since     = 0;
      end
      if (err_timeout) begin
        tos++;
        to_cyc = since;
      end
      if (committed && !busy) begin
        done = 1;
      end else begin
        if (busy) bus.buf_in_ready = 1'b0;  // must be ignored once granted
        bus.buf_in_commit_ack = committed && v.ack_dly > 0 && since == v.ack_dly;
        phase = ~phase;
        drive();
        prev_acc = bus.req_valid & bus.req_ready;
      end
    end
    bus.buf_in_commit_ack = 1'b0;
    chk("pkt_done", 32'(done), 1);
    chk("n_writes", writes, v.exp_len);
    chk("n_accepted", acc, v.len);
    chk("n_commits", commits, 1);
    chk("n_timeouts", tos, 32'(v.exp_to));
    if (v.exp_to) chk("timeout_cycle", to_cyc, ACK_TIMEOUT);
    chk("len_held", 32'(bus.buf_in_commit_len), v.exp_len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] prev;
    int         w;
    //            mask     len  ack rdy st  g  len  ovf to
    vecs[0]  = '{4'b0001,   3,   2,  0, 0, 0,   3, 0, 0};
    vecs[1]  = '{4'b1111,   1,   1,  0, 0, 1,   1, 0, 0};
    vecs[2]  = '{4'b1111,   1,   1,  0, 1, 2,   1, 0, 0};
    vecs[3]  = '{4'b1111,   1,   2,  0, 0, 3,   1, 0, 0};
    vecs[4]  = '{4'b1111,   1,   1,  0, 0, 0,   1, 0, 0};
    vecs[5]  = '{4'b0100, 515,   3,  0, 0, 2, 512, 1, 0};
    vecs[6]  = '{4'b1010,   2,  -1,  0, 0, 3,   2, 0, 1};
    vecs[7]  = '{4'b1111,   4,   1,  3, 1, 0,   4, 0, 0};
    vecs[8]  = '{4'b0110,   5,   4,  0, 0, 1,   5, 0, 0};
    vecs[9]  = '{4'b0100,   2,   2,  0, 0, 2,   2, 0, 0};
    vecs[10] = '{4'b1001,   3,   1,  0, 0, 0,   3, 0, 0};

    for (int p = 0; p < 4; p++) pcnt[p] = 0;
    cur_mask = '0; cur_len = 1; cur_stall = 0; phase = 0;
    bus.buf_in_ready = 1'b0;
    bus.buf_in_commit_ack = 1'b0;
    drive();

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wren", 32'(bus.buf_in_wren), 0);
    chk("rst_commit", 32'(bus.buf_in_commit), 0);
    chk("rst_commit_len", 32'(bus.buf_in_commit_len), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_errs", 32'({err_overflow, err_timeout}), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_pkt(vecs[i]);

    // Abort producer 3 mid-packet with reset; last_grant must return to N_REQ-1.
    cur_mask = 4'b1000; cur_len = 10; cur_stall = 0; phase = 0;
    bus.buf_in_ready = 1'b1;
    drive();
    prev = '0;
    w = 0;
    for (int c = 0; c < 40 && w < 5; c++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) if (prev[p]) pcnt[p]++;
      if (bus.buf_in_wren) w++;
      if (w < 5) begin
        if (busy) bus.buf_in_ready = 1'b0;
        drive();
        prev = bus.req_valid & bus.req_ready;
      end
    end
    chk("abort_writes_seen", w, 5);
    chk("abort_busy_before", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_wren", 32'(bus.buf_in_wren), 0);
    chk("abort_ready", 32'(bus.req_ready), 0);
    chk("abort_grant", 32'(grant_id), 0);
    chk("abort_commit_len", 32'(bus.buf_in_commit_len), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_commit", 32'(bus.buf_in_commit), 0);
    end
    reset_n = 1'b1;
    for (int p = 0; p < 4; p++) pcnt[p] = 0;
    run_pkt(vecs[10]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
